// File: rtl/rv_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN         data/address width
//   RESET_PC     PC loaded on reset
//   INST_EBREAK  encoding that stops fetching
//   fetch_state_t  fetch FSM encoding (IDLE/RUN/HALT)
//   fetch_entry_t  one buffered {pc, inst} pair
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handshake.
//   valid  head entry available (driven by fetch)
//   ready  decode accepts the head this cycle (driven by decode)
//   pc     head PC
//   inst   head instruction
interface inst_fetch_if;
  import rv_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;

  modport master (output valid, output pc, output inst, input ready);
  modport slave  (input valid, input pc, input inst, output ready);

endinterface

// File: rtl/inst_fetch_fetch_buf.sv
// fetch_buf: 2-entry in-order {pc, inst} FIFO kept as a head register plus
// one tail register, so the head output keeps its last value once drained.
//   clk, rst_n  clock, synchronous active-low reset
//   enq, din    push din
//   deq         pop head (only meaningful while count != 0)
//   flush       drop all entries; wins over enq/deq
//   count       occupancy 0..2
//   head        oldest entry
module fetch_buf
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq,
  input  fetch_entry_t din,
  input  logic         deq,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t tail;
  logic         tail_load;

  // The tail is written when a push lands behind a surviving head.
  assign tail_load = !flush && enq && ((!deq && count != 2'd0) || (deq && count == 2'd2));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({enq, deq})
        2'b10: begin
          if (count == 2'd0) head <= din;
          count <= 2'(count + 2'd1);
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= 2'(count - 2'd1);
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, queue shifts by one.
          head <= (count == 2'd2) ? tail : din;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the tail storage is not reset; count says whether it is live,
  // so its contents after reset never reach an output.
  always_ff @(posedge clk) begin
    if (tail_load) tail <= din;
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage sitting on inst_rom's CPU read port.
// Holds the PC, reads the ROM combinationally, buffers up to two fetched
// instructions and hands them to decode over a valid/ready handshake.
//   clk, rst_n      clock, synchronous active-low reset
//   boot_done       ROM image loaded; leave IDLE
//   rom_rd_en       ROM read enable
//   rom_addr        ROM byte address (always the PC)
//   rom_inst        ROM data, same cycle as rom_addr
//   redirect_valid  taken branch/jump from EX; flushes and reloads PC
//   redirect_pc     redirect target
//   id              decode handshake (master side)
//   halted          fetch stopped on HALT_INST
//   misalign_err    one-cycle pulse for a redirect target with pc[1:0] != 0
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
  parameter logic [XLEN-1:0] HALT_INST = rv_pkg::INST_EBREAK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                boot_done,
  output logic                rom_rd_en,
  output logic [XLEN-1:0]     rom_addr,
  input  logic [XLEN-1:0]     rom_inst,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  inst_fetch_if.master        id,
  output logic                halted,
  output logic                misalign_err
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            misalign_next;
  logic [1:0]      count;
  fetch_entry_t    head;
  logic            deq;
  logic            fetch;
  logic            is_halt;

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .enq   (fetch),
    .din   ('{pc: pc, inst: rom_inst}),
    .deq   (deq),
    .flush (redirect_valid),
    .count (count),
    .head  (head)
  );

  assign deq      = id.valid && id.ready;
  assign id.valid = (count != 2'd0);
  assign id.pc    = head.pc;
  assign id.inst  = head.inst;

  assign rom_addr  = pc;
  // A read is possible when a slot is free now or frees this cycle.
  assign rom_rd_en = (state == RUN) && ((count != 2'd2) || deq);
  assign fetch     = rom_rd_en && !redirect_valid;
  assign is_halt   = (rom_inst == HALT_INST);
  assign halted    = (state == HALT);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    misalign_next = 1'b0;

    unique case (state)
      IDLE:    if (boot_done) state_next = RUN;
      RUN:     if (fetch && is_halt) state_next = HALT;
      HALT:    ;
      default: state_next = IDLE;
    endcase

    // The halt instruction is buffered but the PC stays on it.
    if (fetch && !is_halt) pc_next = pc + XLEN'(4);

    // Redirect overrides everything and never moves the FSM.
    if (redirect_valid) begin
      state_next    = state;
      pc_next       = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_next = |redirect_pc[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      misalign_err <= misalign_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import rv_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            boot_done;
  logic            rom_rd_en;
  logic [XLEN-1:0] rom_addr;
  logic [XLEN-1:0] rom_inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halted;
  logic            misalign_err;
  logic [XLEN-1:0] halt_addr;

  int checks = 0;
  int errors = 0;

  inst_fetch_if id_bus ();

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .boot_done      (boot_done),
    .rom_rd_en      (rom_rd_en),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id             (id_bus.master),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // ROM model: each word encodes its own address; one chosen address holds ebreak.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  assign rom_inst = (rom_addr == halt_addr) ? 32'h0010_0073 : inst_at(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n          = 1'b0;
    boot_done      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_bus.ready   = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    halt_addr = 32'h0000_0001;  // unaligned: never fetched

    // 1. Reset state, boot hold, then streaming fetch.
    do_reset;
    check("rst_valid",    32'(id_bus.valid), 32'd0);
    check("rst_halted",   32'(halted),       32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_rd_en",    32'(rom_rd_en),    32'd0);
    check("rst_addr",     rom_addr,          32'h0);
    check("rst_id_pc",    id_bus.pc,         32'h0);
    check("rst_id_inst",  id_bus.inst,       32'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("boot_hold_rd_en", 32'(rom_rd_en),    32'd0);
      check("boot_hold_valid", 32'(id_bus.valid), 32'd0);
    end
    boot_done    = 1'b1;
    id_bus.ready = 1'b1;
    #1;
    check("idle_rd_en", 32'(rom_rd_en), 32'd0);
    tick;
    check("run0_addr",  rom_addr,          32'h0);
    check("run0_rd_en", 32'(rom_rd_en),    32'd1);
    check("run0_valid", 32'(id_bus.valid), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick;
      check("stream_addr",  rom_addr,          32'(4 * k));
      check("stream_valid", 32'(id_bus.valid), 32'd1);
      check("stream_pc",    id_bus.pc,         32'(4 * (k - 1)));
      check("stream_inst",  id_bus.inst,       inst_at(32'(4 * (k - 1))));
    end

    // 2. Backpressure fills the buffer, then drains in order.
    do_reset;
    boot_done = 1'b1;
    tick;  // RUN, pc 0
    tick;  // one buffered, pc 4
    for (int i = 0; i < 4; i++) begin
      tick;
      check("full_rd_en", 32'(rom_rd_en),    32'd0);
      check("full_addr",  rom_addr,          32'h8);
      check("full_valid", 32'(id_bus.valid), 32'd1);
      check("full_head",  id_bus.pc,         32'h0);
    end
    id_bus.ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc",   id_bus.pc,   32'(4 * k));
      check("drain_inst", id_bus.inst, inst_at(32'(4 * k)));
      check("drain_addr", rom_addr,    32'(8 + 4 * k));
      tick;
    end

    // 3. Redirect with a full buffer.
    do_reset;
    boot_done = 1'b1;
    tick;
    tick;
    tick;  // buffer holds 0, 4
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    id_bus.ready   = 1'b1;
    tick;
    redirect_valid = 1'b0;
    #1;
    check("redir_valid",    32'(id_bus.valid), 32'd0);
    check("redir_addr",     rom_addr,          32'h40);
    check("redir_misalign", 32'(misalign_err), 32'd0);
    check("redir_rd_en",    32'(rom_rd_en),    32'd1);
    tick;
    check("redir_pc0",   id_bus.pc,         32'h40);
    check("redir_vld0",  32'(id_bus.valid), 32'd1);
    check("redir_addr1", rom_addr,          32'h44);
    tick;
    check("redir_pc1", id_bus.pc, 32'h44);

    // 4. Halt at 0xC, drain, then redirect while halted.
    halt_addr = 32'hC;
    do_reset;
    boot_done    = 1'b1;
    id_bus.ready = 1'b1;
    tick;
    tick;
    tick;
    tick;
    check("pre_halt_addr",   rom_addr,     32'hC);
    check("pre_halt_halted", 32'(halted),  32'd0);
    check("pre_halt_head",   id_bus.pc,    32'h8);
    tick;
    check("halt_halted", 32'(halted),       32'd1);
    check("halt_rd_en",  32'(rom_rd_en),    32'd0);
    check("halt_valid",  32'(id_bus.valid), 32'd1);
    check("halt_pc",     id_bus.pc,         32'hC);
    check("halt_inst",   id_bus.inst,       32'h0010_0073);
    check("halt_addr",   rom_addr,          32'hC);
    tick;
    check("halt_drained", 32'(id_bus.valid), 32'd0);
    check("halt_sticky",  32'(halted),       32'd1);
    check("halt_rd_en2",  32'(rom_rd_en),    32'd0);
    check("halt_pc_hold", id_bus.pc,         32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick;
    redirect_valid = 1'b0;
    #1;
    check("halt_redir_mis",   32'(misalign_err), 32'd1);
    check("halt_redir_addr",  rom_addr,          32'h40);
    check("halt_redir_halt",  32'(halted),       32'd1);
    check("halt_redir_rd_en", 32'(rom_rd_en),    32'd0);
    tick;
    check("halt_mis_pulse", 32'(misalign_err), 32'd0);

    // 5. Misaligned redirect in RUN, then PC wrap.
    halt_addr = 32'h0000_0001;
    do_reset;
    boot_done    = 1'b1;
    id_bus.ready = 1'b1;
    tick;
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick;
    redirect_valid = 1'b0;
    #1;
    check("mis_pulse", 32'(misalign_err), 32'd1);
    check("mis_addr",  rom_addr,          32'h40);
    check("mis_valid", 32'(id_bus.valid), 32'd0);
    check("mis_rd_en", 32'(rom_rd_en),    32'd1);
    tick;
    check("mis_clear", 32'(misalign_err), 32'd0);
    check("mis_id_pc", id_bus.pc,         32'h40);
    check("mis_addr2", rom_addr,          32'h44);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    #1;
    check("wrap_addr0", rom_addr,          32'hFFFF_FFFC);
    check("wrap_mis",   32'(misalign_err), 32'd0);
    tick;
    check("wrap_addr1", rom_addr,  32'h0);
    check("wrap_id_pc", id_bus.pc, 32'hFFFF_FFFC);

    // 6. Reset mid-run with a full buffer.
    do_reset;
    boot_done = 1'b1;
    tick;
    tick;
    tick;
    check("pre_rst_rd_en", 32'(rom_rd_en),    32'd0);
    check("pre_rst_valid", 32'(id_bus.valid), 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", 32'(id_bus.valid), 32'd0);
    check("mid_rst_addr",  rom_addr,          32'h0);
    check("mid_rst_rd_en", 32'(rom_rd_en),    32'd0);
    check("mid_rst_id_pc", id_bus.pc,         32'h0);
    check("mid_rst_halt",  32'(halted),       32'd0);
    tick;
    check("post_rst_rd_en", 32'(rom_rd_en),    32'd1);
    check("post_rst_valid", 32'(id_bus.valid), 32'd0);
    tick;
    check("post_rst_head",  id_bus.pc,         32'h0);
    check("post_rst_vld",   32'(id_bus.valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
